// File: rtl/wave_pkg.sv
// wave_pkg: shared types and constants for the waveform select/decimate path
package wave_pkg;
    typedef enum logic {ST_RUN, ST_PENDING} sw_state_t;
    localparam int DEF_WIDTH = 12;
    localparam int DEF_N_CH = 4;
    localparam logic [7:0] DROP_MAX = 8'hFF;
endpackage

// File: rtl/decim_strobe.sv
// decim_strobe: programmable decimation strobe, one tick every decim+1 unfrozen cycles
module decim_strobe #(
    parameter int DECIM_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DECIM_W-1:0] i_decim,
    input  logic               i_freeze,
    output logic               o_tick
);
    logic [DECIM_W-1:0] r_cnt;
    assign o_tick = (r_cnt == '0) && !i_freeze;
    // reload on tick, count down otherwise, hold while frozen
    always_ff @(posedge clk) begin
        if (reset) r_cnt <= '0;
        else if (!i_freeze) r_cnt <= (r_cnt == '0) ? i_decim : r_cnt - 1'b1;
    end
endmodule

// File: rtl/wave_select_decimator.sv
// wave_select_decimator: glitch-free channel select, decimation and valid/ready output
module wave_select_decimator
    import wave_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_CH = DEF_N_CH,
    parameter int SEL_W = $clog2(N_CH),
    parameter int DECIM_W = 16,
    parameter bit SYNC_SWITCH = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH*WIDTH-1:0] ch_data,
    input  logic [SEL_W-1:0]      select,
    input  logic                  sel_load,
    input  logic                  sync_pulse,
    input  logic [DECIM_W-1:0]    decim,
    input  logic                  freeze,
    output logic [WIDTH-1:0]      out_sample,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      active_sel,
    output logic                  switch_pending,
    output logic [7:0]            drop_count
);
    sw_state_t        r_state, w_state_nxt;
    logic [SEL_W-1:0] r_active_sel, r_pending_sel, w_active_nxt, w_pending_nxt;
    logic [WIDTH-1:0] r_sample_q, r_out_sample;
    logic             r_out_valid;
    logic [7:0]       r_drop;
    logic             w_tick, w_sel_ok, w_sel_new;

    assign w_sel_ok  = sel_load && (32'(select) < 32'(N_CH));
    assign w_sel_new = w_sel_ok && (select != r_active_sel);

    decim_strobe #(.DECIM_W(DECIM_W)) u_strobe (
        .clk     (clk),
        .reset   (reset),
        .i_decim (decim),
        .i_freeze(freeze),
        .o_tick  (w_tick)
    );

    // switch FSM next state: defer to sync_pulse unless immediate switching is configured
    always_comb begin
        w_state_nxt   = r_state;
        w_active_nxt  = r_active_sel;
        w_pending_nxt = r_pending_sel;
        if (!SYNC_SWITCH) begin
            w_state_nxt  = ST_RUN;
            w_active_nxt = w_sel_ok ? select : r_active_sel;
        end else if (r_state == ST_RUN) begin
            if (w_sel_new && sync_pulse) w_active_nxt = select;
            else if (w_sel_new) begin
                w_pending_nxt = select;
                w_state_nxt   = ST_PENDING;
            end
        end else begin
            if (w_sel_ok && !w_sel_new) w_state_nxt = ST_RUN;
            else if (w_sel_new && sync_pulse) begin
                w_active_nxt = select;
                w_state_nxt  = ST_RUN;
            end else if (w_sel_new) w_pending_nxt = select;
            else if (sync_pulse) begin
                w_active_nxt = r_pending_sel;
                w_state_nxt  = ST_RUN;
            end
        end
    end

    // switch state and channel registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_active_sel  <= '0;
            r_pending_sel <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_active_sel  <= w_active_nxt;
            r_pending_sel <= w_pending_nxt;
        end
    end

    // stage 1 capture, then tick-driven output register with saturating drop count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample_q   <= '0;
            r_out_sample <= '0;
            r_out_valid  <= 1'b0;
            r_drop       <= '0;
        end else begin
            r_sample_q <= ch_data[int'(r_active_sel)*WIDTH +: WIDTH];
            if (w_tick) begin
                r_out_sample <= r_sample_q;
                r_out_valid  <= 1'b1;
                if (r_out_valid && !out_ready && r_drop != DROP_MAX) r_drop <= r_drop + 8'd1;
            end else if (r_out_valid && out_ready) r_out_valid <= 1'b0;
        end
    end

    assign out_sample     = r_out_sample;
    assign out_valid      = r_out_valid;
    assign active_sel     = r_active_sel;
    assign switch_pending = (r_state == ST_PENDING);
    assign drop_count     = r_drop;
endmodule
